// File: rtl/debug_uart_tx_sched.sv
// Shares the debug UART between a CPU byte FIFO and a trace source, round-robin.
// Latency: a byte pushed into an empty FIFO while idle is latched next cycle; tx_en follows one cycle later.
// Backpressure: CPU writes to a full FIFO are dropped and flagged; trace holds trc_req until trc_ack.
module debug_uart_tx_sched #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_wr,
    input  logic [7:0]               cpu_wdata,
    output logic [$clog2(DEPTH):0]   cpu_level,
    output logic                     cpu_full,
    output logic                     cpu_busy,
    output logic                     overflow,
    input  logic                     overflow_clr,
    input  logic                     trc_req,
    input  logic [7:0]               trc_data,
    output logic                     trc_ack,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, ARM, DRAIN} state_t;

    // Grant encoding for last_grant / grant_trc: 1 = trace, 0 = CPU
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    state_t        state_nxt;
    logic          last_grant;
    logic          grant_trc;
    logic          cpu_rdy;
    logic          launch;
    logic          pick_trc;
    logic          fifo_pop;
    logic          fifo_push;
    logic          drop;

    assign cpu_rdy   = (cpu_level != '0);
    assign cpu_full  = (cpu_level == LW'(DEPTH));
    assign cpu_busy  = cpu_rdy || (state != IDLE);
    assign fifo_pop  = launch && !pick_trc;
    // A full FIFO still takes a write when the same cycle frees a slot
    assign fifo_push = cpu_wr && (!cpu_full || fifo_pop);
    assign drop      = cpu_wr && !fifo_push;

    // Outputs decode registered state only, so no input reaches them combinationally
    assign tx_en     = (state == LAUNCH);
    assign trc_ack   = (state == LAUNCH) && grant_trc;

    // Next-state, arbitration and launch decision
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        pick_trc  = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && (cpu_rdy || trc_req)) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                    if (cpu_rdy && trc_req) begin
                        pick_trc = !last_grant;
                    end else begin
                        pick_trc = trc_req;
                    end
                end
            end
            LAUNCH:  state_nxt = ARM;
            // uart_tx raises busy only the cycle after en, so skip one cycle before watching it
            ARM:     state_nxt = DRAIN;
            DRAIN:   if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant history and the latched byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_trc  <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (launch) begin
                last_grant <= pick_trc;
                grant_trc  <= pick_trc;
                tx_data    <= pick_trc ? trc_data : mem[rd_ptr];
            end
        end
    end

    // FIFO storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (fifo_push) mem[wr_ptr] <= cpu_wdata;
    end

    // FIFO pointers, occupancy and sticky overflow (a drop beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cpu_level <= '0;
            overflow  <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   cpu_level <= cpu_level + LW'(1);
                2'b01:   cpu_level <= cpu_level - LW'(1);
                default: cpu_level <= cpu_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_debug_uart_tx_sched.sv
// Directed bench for debug_uart_tx_sched with a behavioural uart_tx busy model.
// Inputs driven and outputs sampled on the falling edge; transmitted bytes collected in a queue.
// tx_busy is the model's busy OR a forced hold used to stall launches.
module tb_debug_uart_tx_sched;
    localparam int FRAME = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic [2:0] cpu_level;
    logic       cpu_full;
    logic       cpu_busy;
    logic       overflow;
    logic       overflow_clr;
    logic       trc_req;
    logic [7:0] trc_data;
    logic       trc_ack;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic       busy_force;
    logic [4:0] cnt;
    logic [7:0] sent [$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int n;
    int acks;
    logic bad;

    debug_uart_tx_sched #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_wr       (cpu_wr),
        .cpu_wdata    (cpu_wdata),
        .cpu_level    (cpu_level),
        .cpu_full     (cpu_full),
        .cpu_busy     (cpu_busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .trc_req      (trc_req),
        .trc_data     (trc_data),
        .trc_ack      (trc_ack),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy from the cycle after en for FRAME cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (tx_en) cnt <= 5'(FRAME);
        else if (cnt != 0) cnt <= cnt - 5'd1;
    end
    assign tx_busy = (cnt != 0) | busy_force;

    // Record every launched byte
    always @(negedge clk) begin
        if (rst_n && tx_en) sent.push_back(tx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(cpu_busy == 1'b0 && tx_busy == 1'b0) && k < 2000);
        check(tag, 32'(k < 2000), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00; overflow_clr = 1'b0;
        trc_req = 1'b0; trc_data = 8'h00; busy_force = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_en",    32'(tx_en), 32'd0);
        check("rst_tx_data",  32'(tx_data), 32'h00);
        check("rst_trc_ack",  32'(trc_ack), 32'd0);
        check("rst_level",    32'(cpu_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single CPU byte while idle
        sent.delete();
        cpu_wr = 1'b1; cpu_wdata = 8'h41;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("t1_level_1", 32'(cpu_level), 32'd1);
        check("t1_no_en_yet", 32'(tx_en), 32'd0);
        @(negedge clk);
        check("t1_tx_en", 32'(tx_en), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'h41);
        check("t1_level_0", 32'(cpu_level), 32'd0);
        @(negedge clk);
        check("t1_en_one_cycle", 32'(tx_en), 32'd0);
        check("t1_cpu_busy", 32'(cpu_busy), 32'd1);
        n = 0; bad = 1'b0;
        while (tx_busy && n < 100) begin
            if (!cpu_busy) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("t1_busy_held", 32'(bad), 32'd0);
        check("t1_tx_busy_fell", 32'(tx_busy), 32'd0);
        check("t1_busy_at_fall", 32'(cpu_busy), 32'd1);
        @(negedge clk);
        check("t1_idle", 32'(cpu_busy), 32'd0);
        check("t1_count", 32'(sent.size()), 32'd1);
        check("t1_byte", 32'(sent[0]), 32'h41);

        // 2: back-to-back writes fill the FIFO, sixth is dropped
        sent.delete();
        for (int i = 1; i <= 5; i++) begin
            cpu_wr = 1'b1; cpu_wdata = 8'(i);
            @(negedge clk);
        end
        check("t2_full", 32'(cpu_full), 32'd1);
        check("t2_level", 32'(cpu_level), 32'd4);
        check("t2_no_ovf", 32'(overflow), 32'd0);
        cpu_wdata = 8'h06;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("t2_drop_ovf", 32'(overflow), 32'd1);
        check("t2_drop_level", 32'(cpu_level), 32'd4);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t2_ovf_clr", 32'(overflow), 32'd0);
        wait_idle("t2_drain");
        check("t2_count", 32'(sent.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t2_byte", 32'(sent[i]), 32'(i + 1));

        // 3: round-robin between FIFO and trace
        do_reset();
        sent.delete();
        busy_force = 1'b1;
        cpu_wr = 1'b1; cpu_wdata = 8'hA0;
        @(negedge clk);
        cpu_wdata = 8'hA1;
        @(negedge clk);
        cpu_wr = 1'b0;
        trc_req = 1'b1; trc_data = 8'h55;
        repeat (2) @(negedge clk);
        check("t3_level", 32'(cpu_level), 32'd2);
        check("t3_held", 32'(tx_en), 32'd0);
        busy_force = 1'b0;
        acks = 0; bad = 1'b0; n = 0;
        while (!(trc_req == 1'b0 && !cpu_busy && !tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
            if (trc_ack) begin
                acks++;
                if (!tx_en) bad = 1'b1;
                if (acks == 1) trc_data = 8'h56;
                else trc_req = 1'b0;
            end
        end
        check("t3_done", 32'(n < 500), 32'd1);
        check("t3_acks", 32'(acks), 32'd2);
        check("t3_ack_with_en", 32'(bad), 32'd0);
        check("t3_count", 32'(sent.size()), 32'd4);
        check("t3_b0", 32'(sent[0]), 32'hA0);
        check("t3_b1", 32'(sent[1]), 32'h55);
        check("t3_b2", 32'(sent[2]), 32'hA1);
        check("t3_b3", 32'(sent[3]), 32'h56);

        // 4: write into a full FIFO on the pop cycle is accepted
        sent.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_wr = 1'b1; cpu_wdata = 8'(8'hB0 + i);
            @(negedge clk);
        end
        check("t4_full", 32'(cpu_full), 32'd1);
        cpu_wdata = 8'hB4;
        busy_force = 1'b0;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("t4_level", 32'(cpu_level), 32'd4);
        check("t4_no_ovf", 32'(overflow), 32'd0);
        check("t4_tx_en", 32'(tx_en), 32'd1);
        check("t4_tx_data", 32'(tx_data), 32'hB0);
        wait_idle("t4_drain");
        check("t4_count", 32'(sent.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("t4_byte", 32'(sent[i]), 32'(8'hB0 + i));

        // 5: reset during DRAIN with bytes queued
        sent.delete();
        for (int i = 0; i < 4; i++) begin
            cpu_wr = 1'b1; cpu_wdata = 8'(8'hC0 + i);
            @(negedge clk);
        end
        cpu_wr = 1'b0;
        check("t5_level", 32'(cpu_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_en", 32'(tx_en), 32'd0);
        check("t5_rst_level", 32'(cpu_level), 32'd0);
        check("t5_rst_busy", 32'(cpu_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sent.delete();
        repeat (20) @(negedge clk);
        check("t5_quiet", 32'(sent.size()), 32'd0);
        cpu_wr = 1'b1; cpu_wdata = 8'hD5;
        @(negedge clk);
        cpu_wr = 1'b0;
        wait_idle("t5_drain");
        check("t5_count", 32'(sent.size()), 32'd1);
        check("t5_byte", 32'(sent[0]), 32'hD5);

        // 6: tx_busy high from reset release stalls the launch
        rst_n = 1'b0;
        busy_force = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpu_wr = 1'b1; cpu_wdata = 8'hE6;
        @(negedge clk);
        cpu_wr = 1'b0;
        sent.delete();
        repeat (20) @(negedge clk);
        check("t6_quiet", 32'(sent.size()), 32'd0);
        check("t6_level", 32'(cpu_level), 32'd1);
        check("t6_no_en", 32'(tx_en), 32'd0);
        busy_force = 1'b0;
        @(negedge clk);
        check("t6_tx_en", 32'(tx_en), 32'd1);
        check("t6_tx_data", 32'(tx_data), 32'hE6);
        check("t6_level_0", 32'(cpu_level), 32'd0);
        @(negedge clk);
        check("t6_en_one_cycle", 32'(tx_en), 32'd0);
        wait_idle("t6_drain");
        check("t6_count", 32'(sent.size()), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
